// File: rtl/armleocpu_ptw_param_if.sv
// Avalon-MM pipelined read port between the page table walker
// and the memory bus.
interface armleocpu_ptw_param_if #(
  parameter int PPN_W    = 22,
  parameter int VPN_W    = 10,
  parameter int PTE_LOG2 = 2,
  parameter int DATA_W   = 32
);
  localparam int AW = PPN_W + VPN_W + PTE_LOG2;

  logic [AW-1:0]     avl_address;
  logic              avl_read;
  logic [DATA_W-1:0] avl_readdata;
  logic              avl_readdatavalid;
  logic              avl_waitrequest;
  logic [1:0]        avl_response;

  modport master (
    output avl_address,
    output avl_read,
    input  avl_readdata,
    input  avl_readdatavalid,
    input  avl_waitrequest,
    input  avl_response
  );

  modport slave (
    input  avl_address,
    input  avl_read,
    output avl_readdata,
    output avl_readdatavalid,
    output avl_waitrequest,
    output avl_response
  );
endinterface

// File: rtl/armleocpu_ptw_param.sv
// Parametrised page table walker (Sv32 / Sv39-style) with a
// pipelined Avalon-MM read port, A/D checks, bare mode and abort.
module armleocpu_ptw_param #(
  parameter int LEVELS   = 2,
  parameter int VPN_W    = 10,
  parameter int PPN_W    = 22,
  parameter int DATA_W   = 32,
  parameter int PTE_LOG2 = 2,
  parameter int AD_CHECK = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  armleocpu_ptw_param_if.master   avl,
  input  logic                    resolve_request,
  output logic                    resolve_ack,
  input  logic                    resolve_store,
  input  logic                    resolve_abort,
  input  logic [LEVELS*VPN_W-1:0] virtual_address,
  input  logic                    matp_mode,
  input  logic [PPN_W-1:0]        matp_ppn,
  output logic                    resolve_done,
  output logic                    resolve_pagefault,
  output logic                    resolve_accessfault,
  output logic [7:0]              resolve_access_bits,
  output logic [PPN_W-1:0]        resolve_physical_address
);
  localparam int VAW = LEVELS * VPN_W;
  localparam int LW  = $clog2(LEVELS);
  localparam logic [LW-1:0] TOP = LW'(LEVELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [VAW-1:0]    va_q, va_d;
  logic              store_q, store_d;
  logic [PPN_W-1:0]  base_q, base_d;
  logic [LW-1:0]     level_q, level_d;
  logic              pf_q, pf_d;
  logic              af_q, af_d;
  logic [7:0]        bits_q, bits_d;
  logic [PPN_W-1:0]  pa_q, pa_d;

  logic [7:0]        flags;
  logic [PPN_W-1:0]  pte_ppn;
  logic              invalid;
  logic              leaf;
  logic              misaligned;
  logic              ad_fault;
  logic              rsv_fault;
  logic [31:0]       shamt;
  logic [PPN_W-1:0]  lo_mask;
  logic [PPN_W-1:0]  va_ext;
  logic [PPN_W-1:0]  va_in_ext;
  logic [PPN_W-1:0]  leaf_pa;
  logic [VPN_W-1:0]  vpn_cur;
  logic              unused_rd;

  assign flags     = avl.avl_readdata[7:0];
  assign pte_ppn   = avl.avl_readdata[10 +: PPN_W];
  assign unused_rd = ^avl.avl_readdata;

  assign invalid = !flags[0] || (flags[2] && !flags[1]);
  assign leaf    = flags[1] || flags[3];

  // lo_mask covers the page offset bits a superpage at this level spans
  assign shamt   = 32'(level_q) * VPN_W;
  assign lo_mask = ~({PPN_W{1'b1}} << shamt);
  assign vpn_cur = VPN_W'(va_q >> shamt);

  if (VAW >= PPN_W) begin : g_trunc
    assign va_ext    = va_q[PPN_W-1:0];
    assign va_in_ext = virtual_address[PPN_W-1:0];
  end else begin : g_zext
    assign va_ext    = {{(PPN_W-VAW){1'b0}}, va_q};
    assign va_in_ext = {{(PPN_W-VAW){1'b0}}, virtual_address};
  end

  assign misaligned = |(pte_ppn & lo_mask);
  assign ad_fault   = (AD_CHECK != 0) &&
                      (!flags[6] || (store_q && !flags[7]));
  assign rsv_fault  = flags[7] || flags[6] || flags[4] ||
                      (level_q == '0);
  assign leaf_pa    = (pte_ppn & ~lo_mask) | (va_ext & lo_mask);

  assign avl.avl_address = {base_q, vpn_cur, {PTE_LOG2{1'b0}}};
  assign avl.avl_read    = (state_q == S_READ);

  assign resolve_ack              = (state_q == S_IDLE);
  assign resolve_done             = (state_q == S_DONE);
  assign resolve_pagefault        = pf_q;
  assign resolve_accessfault      = af_q;
  assign resolve_access_bits      = bits_q;
  assign resolve_physical_address = pa_q;

  always_comb begin
    state_d = state_q;
    va_d    = va_q;
    store_d = store_q;
    base_d  = base_q;
    level_d = level_q;
    pf_d    = pf_q;
    af_d    = af_q;
    bits_d  = bits_q;
    pa_d    = pa_q;
    unique case (state_q)
      S_IDLE: begin
        if (resolve_request) begin
          va_d    = virtual_address;
          store_d = resolve_store;
          base_d  = matp_ppn;
          level_d = TOP;
          if (!matp_mode) begin
            state_d = S_DONE;
            pa_d    = va_in_ext;
            bits_d  = 8'hCF;
            pf_d    = 1'b0;
            af_d    = 1'b0;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (resolve_abort) begin
          state_d = avl.avl_waitrequest ? S_IDLE : S_DRAIN;
        end else if (!avl.avl_waitrequest) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (resolve_abort) begin
          state_d = avl.avl_readdatavalid ? S_IDLE : S_DRAIN;
        end else if (avl.avl_readdatavalid) begin
          state_d = S_DONE;
          pf_d    = 1'b0;
          af_d    = 1'b0;
          bits_d  = flags;
          pa_d    = '0;
          if (avl.avl_response != 2'b00) begin
            af_d   = 1'b1;
            bits_d = '0;
          end else if (invalid) begin
            pf_d = 1'b1;
          end else if (leaf) begin
            if (misaligned || ad_fault) begin
              pf_d = 1'b1;
            end else begin
              pa_d = leaf_pa;
            end
          end else if (rsv_fault) begin
            pf_d = 1'b1;
          end else begin
            base_d  = pte_ppn;
            level_d = level_q - 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DRAIN: begin
        if (avl.avl_readdatavalid) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      va_q    <= '0;
      store_q <= 1'b0;
      base_q  <= '0;
      level_q <= TOP;
      pf_q    <= 1'b0;
      af_q    <= 1'b0;
      bits_q  <= '0;
      pa_q    <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= va_d;
      store_q <= store_d;
      base_q  <= base_d;
      level_q <= level_d;
      pf_q    <= pf_d;
      af_q    <= af_d;
      bits_q  <= bits_d;
      pa_q    <= pa_d;
    end
  end
endmodule

// File: tb/tb_armleocpu_ptw_param.sv
// Randomised and directed bench for armleocpu_ptw_param against
// a behavioural Sv32 walk model and a pipelined Avalon slave.
module tb_armleocpu_ptw_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        resolve_request;
  logic        resolve_ack;
  logic        resolve_store;
  logic        resolve_abort;
  logic [19:0] virtual_address;
  logic        matp_mode;
  logic [21:0] matp_ppn;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [7:0]  resolve_access_bits;
  logic [21:0] resolve_physical_address;

  armleocpu_ptw_param_if #(
    .PPN_W(22), .VPN_W(10), .PTE_LOG2(2), .DATA_W(32)
  ) av ();

  armleocpu_ptw_param dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .avl                      (av),
    .resolve_request          (resolve_request),
    .resolve_ack              (resolve_ack),
    .resolve_store            (resolve_store),
    .resolve_abort            (resolve_abort),
    .virtual_address          (virtual_address),
    .matp_mode                (matp_mode),
    .matp_ppn                 (matp_ppn),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_access_bits      (resolve_access_bits),
    .resolve_physical_address (resolve_physical_address)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_rv_cyc = 0;

  bit [31:0]   mem   [bit [33:0]];
  bit          err_m [bit [33:0]];
  logic [33:0] rd_log[$];
  logic [33:0] exp_addr[$];

  int cfg_stall = 0;
  int cfg_lat = 1;
  bit cfg_rand = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pipelined Avalon slave, one read in flight, driven on negedges
  initial begin
    bit          pend;
    bit          busy;
    int          stall_left;
    int          lat_left;
    logic [33:0] hold_addr;
    logic [31:0] p_data;
    logic [1:0]  p_resp;
    pend = 0;
    busy = 0;
    stall_left = 0;
    lat_left = 0;
    hold_addr = '0;
    p_data = '0;
    p_resp = '0;
    av.avl_waitrequest   = 1'b0;
    av.avl_readdatavalid = 1'b0;
    av.avl_readdata      = '0;
    av.avl_response      = '0;
    forever begin
      @(negedge clk);
      av.avl_readdatavalid = 1'b0;
      if (!rst_n) begin
        pend = 0;
        busy = 0;
      end
      if (pend) begin
        if (lat_left <= 1) begin
          av.avl_readdatavalid = 1'b1;
          av.avl_readdata = p_data;
          av.avl_response = p_resp;
          pend = 0;
          last_rv_cyc = cyc + 1;
        end else begin
          lat_left--;
        end
      end
      if (av.avl_read) begin
        if (!busy) begin
          busy = 1;
          hold_addr = av.avl_address;
          stall_left = cfg_rand ? int'($urandom_range(0, 3))
                                : cfg_stall;
        end else begin
          chk("addr_stable", av.avl_address, hold_addr);
        end
        if (stall_left > 0) begin
          av.avl_waitrequest = 1'b1;
          stall_left--;
        end else begin
          av.avl_waitrequest = 1'b0;
          chk("one_outstanding", pend, 0);
          rd_log.push_back(av.avl_address);
          p_data = mem.exists(av.avl_address) ?
                   mem[av.avl_address] : 32'h0;
          p_resp = err_m.exists(av.avl_address) ? 2'b10 : 2'b00;
          pend = 1;
          lat_left = cfg_rand ? int'($urandom_range(1, 4)) : cfg_lat;
          busy = 0;
        end
      end else begin
        av.avl_waitrequest = 1'b0;
        busy = 0;
      end
    end
  end

  // Sv32 walk as the privileged spec describes it
  task automatic model(input logic [21:0] root, input logic [19:0] va,
                       input bit st, input bit mode,
                       output bit pf, output bit af,
                       output logic [7:0] bits, output logic [21:0] pa);
    logic [21:0] base;
    logic [33:0] a;
    logic [31:0] pte;
    logic [7:0]  f;
    logic [21:0] p;
    int          vpn;
    pf = 0;
    af = 0;
    bits = 8'hCF;
    pa = {2'b00, va};
    exp_addr.delete();
    if (!mode) return;
    bits = '0;
    pa = '0;
    base = root;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      vpn = int'(va >> (10 * lvl)) % 1024;
      a = {base, 12'b0} + 34'(vpn * 4);
      exp_addr.push_back(a);
      if (err_m.exists(a)) begin
        af = 1;
        return;
      end
      pte = mem.exists(a) ? mem[a] : 32'h0;
      f = pte[7:0];
      p = pte[31:10];
      if (!f[0] || (f[2] && !f[1])) begin
        pf = 1;
        return;
      end
      if (f[1] || f[3]) begin
        if (lvl == 1 && (p % 1024) != 0) pf = 1;
        else if (!f[6] || (st && !f[7])) pf = 1;
        else begin
          bits = f;
          pa = (lvl == 1) ? (p / 1024) * 1024 + 22'(va % 1024) : p;
        end
        return;
      end
      if (f[7] || f[6] || f[4] || lvl == 0) begin
        pf = 1;
        return;
      end
      base = p;
    end
  endtask

  task automatic walk(input string nm, input logic [21:0] root,
                      input logic [19:0] va, input bit st,
                      input bit mode);
    bit          pf;
    bit          af;
    logic [7:0]  bits;
    logic [21:0] pa;
    int          t0;
    bit          seen;
    model(root, va, st, mode, pf, af, bits, pa);
    rd_log.delete();
    @(negedge clk); #1;
    chk({nm, "_ack"}, resolve_ack, 1);
    resolve_request = 1'b1;
    matp_ppn = root;
    virtual_address = va;
    resolve_store = st;
    matp_mode = mode;
    t0 = cyc;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      resolve_request = 1'b0;
      if (resolve_done) seen = 1;
    end
    chk({nm, "_done"}, seen, 1);
    if (seen) begin
      chk({nm, "_lat"}, cyc, mode ? last_rv_cyc : t0 + 1);
      chk({nm, "_pf"}, resolve_pagefault, pf);
      chk({nm, "_af"}, resolve_accessfault, af);
      if (!pf && !af) begin
        chk({nm, "_pa"}, resolve_physical_address, pa);
        chk({nm, "_bits"}, resolve_access_bits, bits);
      end
      chk({nm, "_nreads"}, rd_log.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size() && i < rd_log.size(); i++)
        chk({nm, "_addr"}, rd_log[i], exp_addr[i]);
      @(negedge clk); #1;
      chk({nm, "_pulse"}, resolve_done, 0);
    end
  endtask

  task automatic start_paged();
    rd_log.delete();
    @(negedge clk); #1;
    resolve_request = 1'b1;
    matp_ppn = 22'h100;
    virtual_address = 20'h12345;
    resolve_store = 1'b0;
    matp_mode = 1'b1;
  endtask

  task automatic abort_wait(input string nm, input int lat);
    bit ok;
    bit d;
    cfg_stall = 0;
    cfg_lat = lat;
    start_paged();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      resolve_request = 1'b0;
      if (av.avl_read && !av.avl_waitrequest) ok = 1;
    end
    chk({nm, "_accept"}, ok, 1);
    @(negedge clk); #1;
    resolve_abort = 1'b1;
    @(negedge clk); #1;
    resolve_abort = 1'b0;
    chk({nm, "_ack_early"}, resolve_ack, lat == 1);
    d = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (resolve_done) d = 1;
    end
    chk({nm, "_nodone"}, d, 0);
    chk({nm, "_ack"}, resolve_ack, 1);
    chk({nm, "_reads"}, rd_log.size(), 1);
  endtask

  task automatic stall_then(input string nm, input bit do_reset);
    bit ok;
    cfg_stall = 5;
    cfg_lat = 1;
    start_paged();
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); #1;
      resolve_request = 1'b0;
      if (av.avl_read && av.avl_waitrequest) ok = 1;
    end
    chk({nm, "_stalled"}, ok, 1);
    if (do_reset) begin
      rst_n = 1'b0;
      #1;
      chk({nm, "_read"}, av.avl_read, 0);
      chk({nm, "_ack"}, resolve_ack, 1);
      @(negedge clk); #1;
      rst_n = 1'b1;
    end else begin
      resolve_abort = 1'b1;
      @(negedge clk); #1;
      resolve_abort = 1'b0;
      chk({nm, "_ack"}, resolve_ack, 1);
      chk({nm, "_read"}, av.avl_read, 0);
    end
    chk({nm, "_reads"}, rd_log.size(), 0);
  endtask

  function automatic logic [33:0] pte_at(input logic [21:0] base,
                                         input logic [9:0] vpn);
    return {base, vpn, 2'b00};
  endfunction

  task automatic clr();
    mem.delete();
    err_m.delete();
  endtask

  task automatic set_4k(input logic [31:0] leaf);
    clr();
    mem[pte_at(22'h100, 10'h048)] = 32'h0080_0001;
    mem[pte_at(22'h2000, 10'h345)] = leaf;
  endtask

  logic [7:0] ftab [8];

  initial begin
    logic [21:0] root;
    logic [19:0] va;
    logic [21:0] p1;
    logic [21:0] p0;
    logic [33:0] a1;
    logic [33:0] a0;
    ftab = '{8'h01, 8'h01, 8'hCF, 8'h4F, 8'h8F, 8'h05, 8'h00, 8'h51};
    resolve_request = 1'b0;
    resolve_store = 1'b0;
    resolve_abort = 1'b0;
    virtual_address = '0;
    matp_mode = 1'b0;
    matp_ppn = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", resolve_ack, 1);
    chk("rst_done", resolve_done, 0);
    chk("rst_pf", resolve_pagefault, 0);
    chk("rst_af", resolve_accessfault, 0);
    chk("rst_bits", resolve_access_bits, 0);
    chk("rst_pa", resolve_physical_address, 0);
    chk("rst_read", av.avl_read, 0);
    rst_n = 1'b1;

    set_4k(32'h02AF_00CF);
    walk("sv32_4k", 22'h100, 20'h12345, 0, 1);
    chk("sv32_4k_pa_abs", resolve_physical_address, 22'h0ABC0);

    clr();
    mem[pte_at(22'h100, 10'h048)] = 32'h0100_00CF;
    walk("mega", 22'h100, 20'h12345, 0, 1);
    chk("mega_pa_abs", resolve_physical_address, 22'h04345);
    mem[pte_at(22'h100, 10'h048)] = 32'h0100_04CF;
    walk("mega_misal", 22'h100, 20'h12345, 0, 1);

    set_4k(32'h02AF_008F);
    walk("ad_noa", 22'h100, 20'h12345, 0, 1);
    set_4k(32'h02AF_004F);
    walk("ad_st", 22'h100, 20'h12345, 1, 1);
    walk("ad_ld", 22'h100, 20'h12345, 0, 1);

    set_4k(32'h02AF_00CF);
    err_m[pte_at(22'h100, 10'h048)] = 1'b1;
    walk("buserr", 22'h100, 20'h12345, 0, 1);
    set_4k(32'h0000_0401);
    walk("l0_ptr", 22'h100, 20'h12345, 0, 1);
    clr();
    mem[pte_at(22'h100, 10'h048)] = 32'h0000_0005;
    walk("w_no_r", 22'h100, 20'h12345, 0, 1);

    set_4k(32'h02AF_00CF);
    cfg_stall = 3;
    cfg_lat = 4;
    walk("stall", 22'h100, 20'h12345, 0, 1);

    abort_wait("abort_wait", 3);
    abort_wait("abort_same", 1);
    stall_then("abort_read", 0);
    stall_then("rst_mid", 1);

    cfg_stall = 0;
    cfg_lat = 1;
    walk("bare", 22'h100, 20'h12345, 0, 0);
    chk("bare_pa_abs", resolve_physical_address, 22'h012345);

    cfg_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      root = 22'($urandom);
      va = 20'($urandom);
      p1 = 22'($urandom);
      p0 = 22'($urandom);
      if ($urandom_range(0, 1) == 0) p1[9:0] = '0;
      clr();
      a1 = pte_at(root, va[19:10]);
      mem[a1] = {p1, 2'b00, ftab[$urandom_range(0, 7)]};
      a0 = pte_at(p1, va[9:0]);
      mem[a0] = {p0, 2'b00, ftab[$urandom_range(0, 7)]};
      if ($urandom_range(0, 7) == 0) err_m[a1] = 1'b1;
      if ($urandom_range(0, 7) == 0) err_m[a0] = 1'b1;
      walk("rnd", root, va, 1'($urandom_range(0, 1)),
           $urandom_range(0, 5) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
